fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Two-entry instruction queue between the fetch stage and decode.
- Captures each valid fetched word together with the PC it was fetched from, and presents them in order to decode through a valid/ready handshake.
- Drives the fetch stall input to throttle fetch, and discards all queued entries on a branch flush.
- Keeps a saturating count of discarded entries for performance monitoring.

Parameters:
ADDR_W, 16, width of PC/address fields (matches the fetch address width)
INST_W, 32, instruction word width
CNT_W, 16, width of flush-drop counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
v_i  input  1  fetch output valid; pc_i/inst_i are meaningful only when high
pc_i  input  ADDR_W  address the current word was fetched from
inst_i  input  INST_W  instruction word, aligned with pc_i
stall_o  output  1  to fetch stall input; high = fetch must hold
flush_i  input  1  branch taken/resolved; discard all queued and incoming entries
v_o  output  1  head entry valid to decode
pc_o  output  ADDR_W  head entry PC
inst_o  output  INST_W  head entry instruction
ready_i  input  1  decode accepts head this cycle
drop_cnt_o  output  CNT_W  number of valid entries discarded by flush, saturating

Behaviour:
- Storage: two entry registers, E0 (head) and E1, each holding {pc, inst}. State register with three states: EMPTY, ONE, FULL.
- Outputs: v_o = (state != EMPTY); pc_o/inst_o = E0. stall_o = (state == FULL). It is a pure function of state, so there is no combinational path from ready_i or v_i to stall_o.
- push = v_i & ~stall_o & ~flush_i. pop = v_o & ready_i & ~flush_i.
- Fetch holds pc_i/inst_i/v_i steady while stall_o is high. Therefore an item is pushed exactly once, in the cycle stall_o is low.
- Transitions without flush:
  - EMPTY + push -> ONE, E0 <= input.
  - ONE + push, no pop -> FULL, E1 <= input.
  - ONE + pop, no push -> EMPTY.
  - ONE + push + pop -> ONE, E0 <= input.
  - FULL + pop -> ONE, E0 <= E1. Push is impossible in FULL.
  - No push and no pop -> state and entries hold.
- Latency: an input pushed in cycle N appears on v_o/pc_o/inst_o in cycle N+1 if the queue was EMPTY, or ONE with a pop in N.
- Flush:
  - flush_i high in cycle N -> state <= EMPTY at edge N. Input in cycle N is not pushed, and head is not considered consumed.
  - drop_cnt_o += number of entries held (0, 1 or 2), plus 1 if v_i was high, saturating at 2^CNT_W-1.
  - Flush wins over simultaneous push/pop.
- Entry data registers need not clear on pop or flush. v_o alone qualifies them; the bench must not check pc_o/inst_o while v_o is low.
- Reset (rst low, any time, including mid-transfer), asynchronously:
  - state = EMPTY, so v_o = 0 and stall_o = 0.
  - E0 = E1 = 0, so pc_o = 0 and inst_o = 0.
  - drop_cnt_o = 0.
- Ordering: entries leave in exact push order; no duplication and no loss except by flush.
- drop_cnt_o arithmetic: computed at CNT_W+2 bits, then clamped.

Test Plan:
1. Reset, then v_i=1 with pc_i=0,1,2,… each cycle and ready_i=1 continuously -> v_o rises one cycle after first push. pc_o sequence is 0,1,2,… with no gaps. stall_o stays 0.
2. ready_i=0 while pushing pc 5,6 -> FULL after two pushes, stall_o=1, pc_o=5 held. Raise ready_i for one cycle -> pc_o=6 next cycle and stall_o=0. The word held by fetch (pc 7) is pushed exactly once.
3. FULL (pc 10,11) with v_i=1 (pc 12), assert flush_i one cycle -> next cycle v_o=0, stall_o=0 and drop_cnt_o=3. The following push of pc 40 appears as head one cycle later.
4. State ONE with push and pop in the same cycle (head pc 3, input pc 4) -> stays ONE with pc_o=4. No FULL and no stall.
5. Assert rst low mid-stream with the queue FULL -> immediately, without a clock edge, v_o=0, stall_o=0, pc_o=0, inst_o=0 and drop_cnt_o=0. After release, normal operation resumes from the first new push.
6. CNT_W=2: flush a FULL queue with v_i=1 twice -> drop_cnt_o goes 3, then stays 3 (saturated).

Source files
------------

// File: rtl/fetch_queue.sv
// Two-entry in-order instruction queue between fetch and decode.
// Throttles fetch via stall_o, drops everything on flush, counts drops.
module fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              v_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int ENT_W = ADDR_W + INST_W;
  localparam int SUM_W = CNT_W + 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [ENT_W-1:0] e0_q, e0_d;
  logic [ENT_W-1:0] e1_q, e1_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             push;
  logic             pop;
  logic [ENT_W-1:0] in_ent;
  logic [1:0]       held;
  logic [SUM_W-1:0] drop_sum;

  // Outputs depend on registered state only, so stall_o has no path from ready_i/v_i.
  assign v_o        = (state_q != ST_EMPTY);
  assign stall_o    = (state_q == ST_FULL);
  assign pc_o       = e0_q[ENT_W-1:INST_W];
  assign inst_o     = e0_q[INST_W-1:0];
  assign drop_cnt_o = drop_q;

  assign push   = v_i & ~stall_o & ~flush_i;
  assign pop    = v_o & ready_i & ~flush_i;
  assign in_ent = {pc_i, inst_i};

  always_comb begin
    held = 2'd0;
    case (state_q)
      ST_ONE:  held = 2'd1;
      ST_FULL: held = 2'd2;
      default: held = 2'd0;
    endcase
  end

  // Incoming valid word counts as dropped too; wide sum avoids wrap before the clamp.
  assign drop_sum = {2'b00, drop_q} + SUM_W'(held) + SUM_W'(v_i);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    drop_d  = drop_q;

    if (flush_i) begin
      state_d = ST_EMPTY;
      if (drop_sum > {2'b00, CNT_MAX}) begin
        drop_d = CNT_MAX;
      end else begin
        drop_d = drop_sum[CNT_W-1:0];
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            e0_d    = in_ent;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            e0_d = in_ent;
          end else if (push) begin
            state_d = ST_FULL;
            e1_d    = in_ent;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ONE;
            e0_d    = e1_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: entry registers are reset as well, so pc_o/inst_o read zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
      drop_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so all flops sample pre-edge values together.
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of pushed {pc,inst} plus
// per-scenario inline checks; a second instance with CNT_W=2 covers saturation.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        v_i;
  logic [15:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        ready_i;

  logic        stall_o, v_o;
  logic [15:0] pc_o;
  logic [31:0] inst_o;
  logic [15:0] drop_cnt_o;

  logic        stall2_o, v2_o;
  logic [15:0] pc2_o;
  logic [31:0] inst2_o;
  logic [1:0]  drop2_o;

  int checks   = 0;
  int failures = 0;

  logic [47:0] sb[$];
  int          exp_drop1 = 0;
  int          exp_drop2 = 0;
  bit          m_v, m_stall, m_pop, m_push;
  int          m_n;

  fetch_queue #(.ADDR_W(16), .INST_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .pc_i(pc_i), .inst_i(inst_i),
    .stall_o(stall_o), .flush_i(flush_i), .v_o(v_o), .pc_o(pc_o),
    .inst_o(inst_o), .ready_i(ready_i), .drop_cnt_o(drop_cnt_o)
  );

  fetch_queue #(.ADDR_W(16), .INST_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .v_i(v_i), .pc_i(pc_i), .inst_i(inst_i),
    .stall_o(stall2_o), .flush_i(flush_i), .v_o(v2_o), .pc_o(pc2_o),
    .inst_o(inst2_o), .ready_i(ready_i), .drop_cnt_o(drop2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [15:0] pc);
    return {~pc, pc} ^ 32'h5A00_00A5;
  endfunction

  // Reference model: outputs compared against model occupancy, then model advanced.
  always @(negedge clk) begin
    if (rst) begin
      m_v     = (sb.size() != 0);
      m_stall = (sb.size() == 2);
      checks++;
      if (v_o !== m_v) begin
        failures++;
        $display("FAIL mon_v_o: got %b want %b at %0t", v_o, m_v, $time);
      end
      checks++;
      if (stall_o !== m_stall) begin
        failures++;
        $display("FAIL mon_stall_o: got %b want %b at %0t", stall_o, m_stall, $time);
      end
      if (m_v) begin
        checks++;
        if ({pc_o, inst_o} !== sb[0]) begin
          failures++;
          $display("FAIL mon_head: got pc=%h inst=%h want pc=%h inst=%h at %0t",
                   pc_o, inst_o, sb[0][47:32], sb[0][31:0], $time);
        end
      end
      checks++;
      if (drop_cnt_o !== 16'(exp_drop1)) begin
        failures++;
        $display("FAIL mon_drop: got %0d want %0d at %0t", drop_cnt_o, exp_drop1, $time);
      end
      checks++;
      if (drop2_o !== 2'(exp_drop2)) begin
        failures++;
        $display("FAIL mon_drop_sat: got %0d want %0d at %0t", drop2_o, exp_drop2, $time);
      end

      if (flush_i) begin
        m_n       = sb.size() + int'(v_i);
        exp_drop1 = (exp_drop1 + m_n > 65535) ? 65535 : exp_drop1 + m_n;
        exp_drop2 = (exp_drop2 + m_n > 3) ? 3 : exp_drop2 + m_n;
        sb.delete();
      end else begin
        m_pop  = m_v && ready_i;
        m_push = v_i && !m_stall;
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back({pc_i, inst_of(pc_i)});
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] pc, input logic rdy,
                       input logic fl);
    v_i     = v;
    pc_i    = pc;
    inst_i  = inst_of(pc);
    ready_i = rdy;
    flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(1'b0, 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; v_i = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0; ready_i = 1'b0;
    #12;
    checks++;
    if ({v_o, stall_o, pc_o, inst_o, drop_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b stall=%b pc=%h inst=%h drop=%0d want all 0",
               v_o, stall_o, pc_o, inst_o, drop_cnt_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      checks++;
      if (v_o !== 1'b1 || pc_o !== 16'(i) || stall_o !== 1'b0) begin
        failures++;
        $display("FAIL stream_head: got v=%b pc=%0d stall=%b want v=1 pc=%0d stall=0",
                 v_o, pc_o, stall_o, i);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'd5, 1'b0, 1'b0);
    drive(1'b1, 16'd6, 1'b0, 1'b0);
    checks++;
    if (stall_o !== 1'b1 || pc_o !== 16'd5) begin
      failures++;
      $display("FAIL bp_full: got stall=%b pc=%0d want stall=1 pc=5", stall_o, pc_o);
    end
    drive(1'b1, 16'd7, 1'b0, 1'b0);
    checks++;
    if (stall_o !== 1'b1 || pc_o !== 16'd5) begin
      failures++;
      $display("FAIL bp_hold: got stall=%b pc=%0d want stall=1 pc=5", stall_o, pc_o);
    end
    drive(1'b1, 16'd7, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0 || pc_o !== 16'd6) begin
      failures++;
      $display("FAIL bp_release: got stall=%b pc=%0d want stall=0 pc=6", stall_o, pc_o);
    end
    drive(1'b1, 16'd7, 1'b0, 1'b0);
    checks++;
    if (stall_o !== 1'b1 || pc_o !== 16'd6) begin
      failures++;
      $display("FAIL bp_refill: got stall=%b pc=%0d want stall=1 pc=6", stall_o, pc_o);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 16'd10, 1'b0, 1'b0);
    drive(1'b1, 16'd11, 1'b0, 1'b0);
    drive(1'b1, 16'd12, 1'b1, 1'b1);
    checks++;
    if (v_o !== 1'b0 || stall_o !== 1'b0 || drop_cnt_o !== 16'd3) begin
      failures++;
      $display("FAIL flush_full: got v=%b stall=%b drop=%0d want v=0 stall=0 drop=3",
               v_o, stall_o, drop_cnt_o);
    end
    drive(1'b1, 16'd40, 1'b0, 1'b0);
    checks++;
    if (v_o !== 1'b1 || pc_o !== 16'd40) begin
      failures++;
      $display("FAIL flush_resume: got v=%b pc=%0d want v=1 pc=40", v_o, pc_o);
    end
    drain();
  endtask

  task automatic test_push_pop();
    drive(1'b1, 16'd3, 1'b0, 1'b0);
    drive(1'b1, 16'd4, 1'b1, 1'b0);
    checks++;
    if (v_o !== 1'b1 || pc_o !== 16'd4 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL push_pop: got v=%b pc=%0d stall=%b want v=1 pc=4 stall=0",
               v_o, pc_o, stall_o);
    end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'd20, 1'b0, 1'b0);
    drive(1'b1, 16'd21, 1'b0, 1'b0);
    v_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({v_o, stall_o, pc_o, inst_o, drop_cnt_o} !== '0 ||
        {v2_o, stall2_o, drop2_o} !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b stall=%b pc=%h inst=%h drop=%0d drop2=%0d want all 0",
               v_o, stall_o, pc_o, inst_o, drop_cnt_o, drop2_o);
    end
    sb.delete();
    exp_drop1 = 0;
    exp_drop2 = 0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 16'd50, 1'b1, 1'b0);
    checks++;
    if (v_o !== 1'b1 || pc_o !== 16'd50) begin
      failures++;
      $display("FAIL reset_resume: got v=%b pc=%0d want v=1 pc=50", v_o, pc_o);
    end
    drain();
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 16'(60 + 3 * r), 1'b0, 1'b0);
      drive(1'b1, 16'(61 + 3 * r), 1'b0, 1'b0);
      drive(1'b1, 16'(62 + 3 * r), 1'b0, 1'b1);
      checks++;
      if (drop2_o !== 2'd3) begin
        failures++;
        $display("FAIL drop_saturate_%0d: got %0d want 3", r, drop2_o);
      end
    end
    checks++;
    if (drop_cnt_o !== 16'd6) begin
      failures++;
      $display("FAIL drop_wide: got %0d want 6", drop_cnt_o);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
